// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural network stream loader.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_X = 2'd2,
        ST_START  = 2'd3
    } ld_state_e;

    localparam logic MODE_WEIGHT = 1'b0;
    localparam logic MODE_INPUT  = 1'b1;

    // Address width for an n-entry range; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nn_addr_counter.sv
// Cascaded syn -> node -> layer wrap counter with runtime terminal values,
// so the same counter walks both the weight space and the input vector.
module nn_addr_counter #(
    parameter int SW = 2,
    parameter int NW = 2,
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [SW-1:0] syn_max,
    input  logic [NW-1:0] node_max,
    input  logic [LW-1:0] layer_max,
    output logic [SW-1:0] syn,
    output logic [NW-1:0] node,
    output logic [LW-1:0] layer,
    output logic          last
);

    logic [SW-1:0] syn_q, syn_d;
    logic [NW-1:0] node_q, node_d;
    logic [LW-1:0] layer_q, layer_d;
    logic          syn_wrap, node_wrap, layer_wrap;

    assign syn_wrap   = (syn_q == syn_max);
    assign node_wrap  = (node_q == node_max);
    assign layer_wrap = (layer_q == layer_max);

    always_comb begin
        syn_d   = syn_q;
        node_d  = node_q;
        layer_d = layer_q;
        if (clr) begin
            syn_d   = '0;
            node_d  = '0;
            layer_d = '0;
        end else if (inc) begin
            // Explicit terminal compares so non-power-of-2 ranges wrap correctly.
            if (syn_wrap) begin
                syn_d = '0;
                if (node_wrap) begin
                    node_d  = '0;
                    layer_d = layer_wrap ? '0 : layer_q + 1'b1;
                end else begin
                    node_d = node_q + 1'b1;
                end
            end else begin
                syn_d = syn_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn_q   <= '0;
            node_q  <= '0;
            layer_q <= '0;
        end else begin
            syn_q   <= syn_d;
            node_q  <= node_d;
            layer_q <= layer_d;
        end
    end

    assign syn   = syn_q;
    assign node  = node_q;
    assign layer = layer_q;
    assign last  = syn_wrap & node_wrap & layer_wrap;

endmodule

// File: rtl/nn_stream_loader.sv
// Fills neural network weight/input memories from a valid/ready word stream,
// with optional one-cycle network start after an input load.
module nn_stream_loader
    import nn_pkg::*;
#(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16,
    parameter int FAN_IN      = LAYER_SIZE,
    localparam int LW = addr_w(LAYER_DEPTH),
    localparam int NW = addr_w(LAYER_SIZE),
    localparam int SW = addr_w(FAN_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mode,
    input  logic                cmd_autostart,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BIT_SIZE-1:0] s_data,
    input  logic                s_last,
    output logic                weight_write_enable,
    output logic                input_write_enable,
    output logic [LW-1:0]       layer,
    output logic [NW-1:0]       node,
    output logic [SW-1:0]       syn,
    output logic [BIT_SIZE-1:0] wdata,
    output logic                net_start,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [SW-1:0] SYN_LAST   = SW'(FAN_IN - 1);
    localparam logic [NW-1:0] NODE_LAST  = NW'(LAYER_SIZE - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_DEPTH - 1);

    ld_state_e           state_q, state_d;
    logic                mode_q, mode_d, auto_q, auto_d, err_q, err_d;
    logic                we_w_q, we_w_d, we_x_q, we_x_d;
    logic                net_start_q, net_start_d, done_q, done_d;
    logic [LW-1:0]       layer_q, layer_d;
    logic [NW-1:0]       node_q, node_d;
    logic [SW-1:0]       syn_q, syn_d;
    logic [BIT_SIZE-1:0] wdata_q, wdata_d;

    logic                cnt_clr, cnt_inc, cnt_last, loading, to_start;
    logic [SW-1:0]       cnt_syn;
    logic [NW-1:0]       cnt_node;
    logic [LW-1:0]       cnt_layer;

    // Input mode views the counter as a single layer with one synapse per node.
    nn_addr_counter #(.SW(SW), .NW(NW), .LW(LW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .syn_max   ((mode_q == MODE_INPUT) ? '0 : SYN_LAST),
        .node_max  (NODE_LAST),
        .layer_max ((mode_q == MODE_INPUT) ? '0 : LAYER_LAST),
        .syn       (cnt_syn),
        .node      (cnt_node),
        .layer     (cnt_layer),
        .last      (cnt_last)
    );

    assign loading  = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
    assign to_start = (state_q == ST_LOAD_X) && auto_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        auto_d      = auto_q;
        err_d       = err_q;
        we_w_d      = 1'b0;
        we_x_d      = 1'b0;
        net_start_d = 1'b0;
        done_d      = 1'b0;
        layer_d     = layer_q;
        node_d      = node_q;
        syn_d       = syn_q;
        wdata_d     = wdata_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    auto_d  = cmd_autostart;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = (cmd_mode == MODE_INPUT) ? ST_LOAD_X : ST_LOAD_W;
                end
            end
            ST_LOAD_W, ST_LOAD_X: begin
                if (s_valid) begin
                    cnt_inc = 1'b1;
                    we_w_d  = (state_q == ST_LOAD_W);
                    we_x_d  = (state_q == ST_LOAD_X);
                    layer_d = cnt_layer;
                    node_d  = cnt_node;
                    syn_d   = cnt_syn;
                    wdata_d = s_data;
                    if (cnt_last) begin
                        state_d = to_start ? ST_START : ST_IDLE;
                        done_d  = !to_start;
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                net_start_d = 1'b1;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WEIGHT;
            auto_q      <= 1'b0;
            err_q       <= 1'b0;
            we_w_q      <= 1'b0;
            we_x_q      <= 1'b0;
            net_start_q <= 1'b0;
            done_q      <= 1'b0;
            layer_q     <= '0;
            node_q      <= '0;
            syn_q       <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            auto_q      <= auto_d;
            err_q       <= err_d;
            we_w_q      <= we_w_d;
            we_x_q      <= we_x_d;
            net_start_q <= net_start_d;
            done_q      <= done_d;
            layer_q     <= layer_d;
            node_q      <= node_d;
            syn_q       <= syn_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready           = (state_q == ST_IDLE);
    assign s_ready             = loading;
    assign busy                = (state_q != ST_IDLE);
    assign weight_write_enable = we_w_q;
    assign input_write_enable  = we_x_q;
    assign layer               = layer_q;
    assign node                = node_q;
    assign syn                 = syn_q;
    assign wdata               = wdata_q;
    assign net_start           = net_start_q;
    assign done                = done_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_nn_stream_loader.sv
// Scoreboard bench for nn_stream_loader: default 4x4 build plus a 3x5 build.
module tb_nn_stream_loader;

    typedef struct packed {
        logic       is_w;
        logic [2:0] layer;
        logic [1:0] node;
        logic [1:0] syn;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        cmd_valid = 0, cmd_mode = 0, cmd_autostart = 0;
    logic        s_valid = 0, s_last = 0;
    logic [15:0] s_data = '0;
    logic        cmd_ready, s_ready, weight_write_enable, input_write_enable;
    logic [1:0]  layer, node, syn;
    logic [15:0] wdata;
    logic        net_start, busy, done, err;

    logic        b_cmd_valid = 0, b_cmd_mode = 0, b_cmd_autostart = 0;
    logic        b_s_valid = 0, b_s_last = 0;
    logic [15:0] b_s_data = '0;
    logic        b_cmd_ready, b_s_ready, b_wwe, b_iwe;
    logic [2:0]  b_layer;
    logic [1:0]  b_node, b_syn;
    logic [15:0] b_wdata;
    logic        b_net_start, b_busy, b_done, b_err;

    wr_t qa[$];
    wr_t qb[$];
    wr_t ea, ga, eb, gb;
    int  total = 0, bad = 0;
    int  a_w = 0, a_x = 0, a_done = 0, a_start = 0, b_w = 0, b_done_cnt = 0;

    nn_stream_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_autostart(cmd_autostart),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .weight_write_enable(weight_write_enable), .input_write_enable(input_write_enable),
        .layer(layer), .node(node), .syn(syn), .wdata(wdata),
        .net_start(net_start), .busy(busy), .done(done), .err(err)
    );

    nn_stream_loader #(.LAYER_SIZE(3), .LAYER_DEPTH(5)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_mode(b_cmd_mode),
        .cmd_autostart(b_cmd_autostart),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .weight_write_enable(b_wwe), .input_write_enable(b_iwe),
        .layer(b_layer), .node(b_node), .syn(b_syn), .wdata(b_wdata),
        .net_start(b_net_start), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    // Write monitors: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (weight_write_enable) a_w++;
        if (input_write_enable) a_x++;
        if (done) a_done++;
        if (net_start) a_start++;
        if (weight_write_enable || input_write_enable) begin
            total++;
            ga = '{is_w: weight_write_enable, layer: {1'b0, layer}, node: node, syn: syn, data: wdata};
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_write got=%h", ga);
            end else begin
                ea = qa.pop_front();
                if (ga !== ea || (weight_write_enable && input_write_enable)) begin
                    bad++;
                    $display("FAIL a_write got=%h want=%h we=%b ie=%b", ga, ea,
                             weight_write_enable, input_write_enable);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_wwe) b_w++;
        if (b_done) b_done_cnt++;
        if (b_wwe || b_iwe) begin
            total++;
            gb = '{is_w: b_wwe, layer: b_layer, node: b_node, syn: b_syn, data: b_wdata};
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_write got=%h", gb);
            end else begin
                eb = qb.pop_front();
                if (gb !== eb || b_iwe) begin
                    bad++;
                    $display("FAIL b_write got=%h want=%h", gb, eb);
                end
            end
        end
    end

    function automatic wr_t wexp(input int k, input int fan, input int ls, input logic [15:0] d);
        wr_t r;
        r.is_w  = 1'b1;
        r.syn   = 2'(k % fan);
        r.node  = 2'((k / fan) % ls);
        r.layer = 3'(k / (fan * ls));
        r.data  = d;
        return r;
    endfunction

    function automatic wr_t xexp(input int k, input logic [15:0] d);
        wr_t r;
        r.is_w  = 1'b0;
        r.syn   = 2'd0;
        r.node  = 2'(k);
        r.layer = 3'd0;
        r.data  = d;
        return r;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic a_cmd(input logic mode, input logic auto_s);
        cmd_valid = 1; cmd_mode = mode; cmd_autostart = auto_s;
        cyc();
        cmd_valid = 0; cmd_autostart = 0;
    endtask

    task automatic a_beat(input logic w, input int k, input logic [15:0] d, input logic last);
        s_valid = 1; s_data = d; s_last = last;
        qa.push_back(w ? wexp(k, 4, 4, d) : xexp(k, d));
        cyc();
        s_valid = 0; s_last = 0;
    endtask

    task automatic test_reset();
        total++;
        if ({weight_write_enable, input_write_enable, layer, node, syn, wdata, net_start, done, err, busy, s_ready} !== '0
            || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got we=%b ie=%b l=%0d n=%0d s=%0d d=%h ns=%b dn=%b er=%b bz=%b sr=%b cr=%b want zeros,cr=1",
                     weight_write_enable, input_write_enable, layer, node, syn, wdata, net_start, done, err, busy, s_ready, cmd_ready);
        end
        cyc();
        rst = 0;
        cyc(); cyc();
        total++;
        if (a_w + a_x !== 0) begin bad++; $display("FAIL reset_no_write got=%0d want=0", a_w + a_x); end
    endtask

    task automatic test_weight_load();
        int w0, d0;
        w0 = a_w; d0 = a_done;
        a_cmd(1'b0, 1'b0);
        total++;
        if (busy !== 1 || cmd_ready !== 0 || s_ready !== 1) begin
            bad++; $display("FAIL wl_handshake got busy=%b cr=%b sr=%b want 1 0 1", busy, cmd_ready, s_ready);
        end
        for (int k = 0; k < 64; k++) begin
            a_beat(1'b1, k, 16'(k), k == 63);
            if (k == 21) begin
                total++;
                if (weight_write_enable !== 1 || layer !== 2'd1 || node !== 2'd1 || syn !== 2'd1 || wdata !== 16'd21) begin
                    bad++; $display("FAIL wl_beat21 got we=%b l=%0d n=%0d s=%0d d=%0d want 1 1 1 1 21",
                                    weight_write_enable, layer, node, syn, wdata);
                end
            end
        end
        total++;
        if (done !== 1 || weight_write_enable !== 1) begin
            bad++; $display("FAIL wl_done_with_last got done=%b we=%b want 1 1", done, weight_write_enable);
        end
        cyc();
        total++;
        if (a_w - w0 !== 64 || a_x !== 0 || a_done - d0 !== 1 || done !== 0 || cmd_ready !== 1 || qa.size() != 0) begin
            bad++; $display("FAIL wl_counts got w=%0d x=%0d done=%0d q=%0d want 64 0 1 0",
                            a_w - w0, a_x, a_done - d0, qa.size());
        end
    endtask

    task automatic test_input_autostart();
        int s0;
        s0 = a_start;
        a_cmd(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) a_beat(1'b0, k, 16'(100 + k), k == 3);
        total++;
        if (input_write_enable !== 1 || done !== 0 || net_start !== 0 || busy !== 1) begin
            bad++; $display("FAIL ia_final_write got ie=%b done=%b ns=%b busy=%b want 1 0 0 1",
                            input_write_enable, done, net_start, busy);
        end
        cyc();
        total++;
        if (net_start !== 1 || done !== 1 || input_write_enable !== 0) begin
            bad++; $display("FAIL ia_start got ns=%b done=%b ie=%b want 1 1 0", net_start, done, input_write_enable);
        end
        cyc();
        total++;
        if (net_start !== 0 || done !== 0 || cmd_ready !== 1 || a_start - s0 !== 1 || qa.size() != 0) begin
            bad++; $display("FAIL ia_after got ns=%b done=%b cr=%b starts=%0d q=%0d want 0 0 1 1 0",
                            net_start, done, cmd_ready, a_start - s0, qa.size());
        end
    endtask

    task automatic test_gaps();
        int w0, gap_bad;
        w0 = a_w; gap_bad = 0;
        a_cmd(1'b0, 1'b0);
        for (int k = 0; k < 64; k++) begin
            a_beat(1'b1, k, 16'(k), k == 63);
            if (k == 63) begin
                total++;
                if (done !== 1) begin bad++; $display("FAIL gap_done got=%b want=1", done); end
            end
            cyc();
            if (weight_write_enable !== 0 || input_write_enable !== 0) gap_bad++;
        end
        total++;
        if (gap_bad !== 0 || a_w - w0 !== 64 || qa.size() != 0) begin
            bad++; $display("FAIL gap_counts got gapstrobes=%0d w=%0d q=%0d want 0 64 0", gap_bad, a_w - w0, qa.size());
        end
    endtask

    task automatic test_early_last();
        int w0, d0, s0;
        w0 = a_w; d0 = a_done; s0 = a_start;
        a_cmd(1'b0, 1'b1);
        for (int k = 0; k <= 10; k++) a_beat(1'b1, k, 16'(500 + k), k == 10);
        total++;
        if (err !== 1 || done !== 0 || cmd_ready !== 1) begin
            bad++; $display("FAIL el_flag got err=%b done=%b cr=%b want 1 0 1", err, done, cmd_ready);
        end
        cyc(); cyc();
        total++;
        if (err !== 1 || a_w - w0 !== 11 || a_done !== d0 || a_start !== s0 || qa.size() != 0) begin
            bad++; $display("FAIL el_sticky got err=%b w=%0d done=%0d ns=%0d want 1 11 0 0",
                            err, a_w - w0, a_done - d0, a_start - s0);
        end
        a_cmd(1'b1, 1'b0);
        total++;
        if (err !== 0) begin bad++; $display("FAIL el_clear got err=%b want 0", err); end
        for (int k = 0; k < 4; k++) a_beat(1'b0, k, 16'(600 + k), 1'b0);
        total++;
        if (done !== 1 || cmd_ready !== 1) begin
            bad++; $display("FAIL el_reload_done got done=%b cr=%b want 1 1", done, cmd_ready);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        a_cmd(1'b0, 1'b0);
        for (int k = 0; k <= 20; k++) a_beat(1'b1, k, 16'(k + 7), 1'b0);
        #2 rst = 1;
        #1;
        total++;
        if ({weight_write_enable, input_write_enable, layer, node, syn, wdata, busy, done, err} !== '0) begin
            bad++; $display("FAIL rm_async got we=%b l=%0d n=%0d s=%0d d=%h busy=%b want zeros",
                            weight_write_enable, layer, node, syn, wdata, busy);
        end
        cyc(); cyc();
        rst = 0;
        cyc(); cyc();
        total++;
        if (busy !== 0 || qa.size() != 0) begin
            bad++; $display("FAIL rm_idle got busy=%b q=%0d want 0 0", busy, qa.size());
        end
        a_cmd(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) a_beat(1'b0, k, 16'(40 + k), k == 3);
        cyc();
        total++;
        if (qa.size() != 0 || cmd_ready !== 1) begin
            bad++; $display("FAIL rm_reload got q=%0d cr=%b want 0 1", qa.size(), cmd_ready);
        end
    endtask

    task automatic test_cmd_ignored();
        int x0;
        x0 = a_x;
        a_cmd(1'b0, 1'b0);
        cmd_valid = 1; cmd_mode = 1;
        for (int k = 0; k < 64; k++) begin
            if (k == 62) cmd_valid = 0;
            if (k == 5) begin
                total++;
                if (cmd_ready !== 0 || busy !== 1) begin
                    bad++; $display("FAIL ci_ready got cr=%b busy=%b want 0 1", cmd_ready, busy);
                end
            end
            a_beat(1'b1, k, 16'(1000 + k), k == 63);
        end
        cmd_mode = 0;
        cyc();
        total++;
        if (a_x !== x0 || qa.size() != 0 || busy !== 0) begin
            bad++; $display("FAIL ci_result got x=%0d q=%0d busy=%b want 0 0 0", a_x - x0, qa.size(), busy);
        end
    endtask

    task automatic test_nonpow2();
        int w0, d0, max_layer, wraps;
        logic [1:0] prev_node;
        w0 = b_w; d0 = b_done_cnt; max_layer = 0; wraps = 0; prev_node = 0;
        b_cmd_valid = 1; b_cmd_mode = 0;
        cyc();
        b_cmd_valid = 0;
        for (int k = 0; k < 45; k++) begin
            b_s_valid = 1; b_s_data = 16'(200 + k); b_s_last = (k == 44);
            qb.push_back(wexp(k, 3, 3, 16'(200 + k)));
            cyc();
            b_s_valid = 0; b_s_last = 0;
            if (prev_node == 2'd2 && b_node == 2'd0) wraps++;
            if (int'(b_layer) > max_layer) max_layer = int'(b_layer);
            prev_node = b_node;
        end
        total++;
        if (b_done !== 1) begin bad++; $display("FAIL np_done got=%b want 1", b_done); end
        cyc();
        total++;
        if (b_w - w0 !== 45 || b_done_cnt - d0 !== 1 || max_layer !== 4 || wraps == 0 || qb.size() != 0) begin
            bad++; $display("FAIL np_counts got w=%0d done=%0d maxlayer=%0d wraps=%0d q=%0d want 45 1 4 >0 0",
                            b_w - w0, b_done_cnt - d0, max_layer, wraps, qb.size());
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_weight_load();
        test_input_autostart();
        test_gaps();
        test_early_last();
        test_reset_mid();
        test_cmd_ignored();
        test_nonpow2();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
